branch_rd_arbiter: RTL and testbench

- Shares the single read port (port B) of the octree branch BRAM between two requesters: the octant builder (OCT) and the BFS traversal core (BFS).
- Round-robin arbitration, with an optional per-requester lock for back-to-back bursts.
- Tracks in-flight reads through the BRAM latency pipeline and returns each 152-bit branch word, with a valid strobe, only to the requester that issued it.
- Sits between the BRAM port-B pins and both cores; the cores no longer drive the BRAM directly.

---
 rtl/branch_rd_arbiter_pkg.sv | 31 +++
 rtl/branch_rd_arbiter_rd_lat_pipe.sv | 57 +++++
 rtl/branch_rd_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_branch_rd_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : branch_rd_arbiter_pkg
// Purpose : Shared constants and encodings for the octree branch BRAM
//           port-B read arbiter and its latency pipeline.
//           - BRANCH_WIDTH : branch word width (8 x 16-bit child + 24-bit payload)
//           - BRAM_ADDR_W  : branch BRAM address width
//           - owner_e      : which requester issued a read
//           - arb_state_e  : arbiter state encoding
// Revision: 1.0 - initial release
// ============================================================================
package branch_rd_arbiter_pkg;

    localparam int BRANCH_WIDTH = 152;
    localparam int BRAM_ADDR_W  = 16;

    // Owner tag carried alongside every in-flight read.
    typedef enum logic [0:0] {
        OWN_OCT = 1'b0,
        OWN_BFS = 1'b1
    } owner_e;

    // Arbiter states. LOCK_* pins the grant to one requester for a burst.
    typedef enum logic [1:0] {
        ARB      = 2'd0,
        LOCK_OCT = 2'd1,
        LOCK_BFS = 2'd2
    } arb_state_e;

endpackage : branch_rd_arbiter_pkg
`default_nettype wire

// File: rtl/branch_rd_arbiter_rd_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module  : rd_lat_pipe
// Purpose : LAT-deep delay line for (valid, owner) pairs. An entry pushed in
//           cycle N appears at the tail in cycle N+LAT, lined up with the
//           BRAM read data for that access.
// Ports   :
//   i_clk       - clock
//   i_rst       - asynchronous active-high reset, empties every stage
//   i_valid     - a read is being issued to the BRAM this cycle
//   i_owner     - requester that issued it
//   o_valid     - tail entry valid (read data returns this cycle)
//   o_owner     - tail entry owner
//   o_any_valid - at least one stage holds a valid entry
// Revision: 1.0 - initial release
// ============================================================================
module rd_lat_pipe
    import branch_rd_arbiter_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_valid,
    input  owner_e i_owner,
    output logic   o_valid,
    output owner_e o_owner,
    output logic   o_any_valid
);

    logic [LAT-1:0] r_valid;
    owner_e         r_owner [LAT];

    // Stage 0 captures the issue; each later stage copies its predecessor.
    // With LAT == 1 the copy loop has no iterations.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_owner[k] <= OWN_OCT;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_owner[0] <= i_owner;
            for (int k = 1; k < LAT; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_owner[k] <= r_owner[k-1];
            end
        end
    end

    assign o_valid     = r_valid[LAT-1];
    assign o_owner     = r_owner[LAT-1];
    assign o_any_valid = |r_valid;

endmodule : rd_lat_pipe
`default_nettype wire

// File: rtl/branch_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : branch_rd_arbiter
// Purpose : Shares port B (read-only) of the octree branch BRAM between the
//           octant builder (OCT) and the BFS traversal core (BFS).
//           Round-robin arbitration with an optional per-requester burst
//           lock; each returned branch word is steered, with a one-cycle
//           valid strobe, back to the requester that issued the read.
// Ports   :
//   i_clk, i_rst            - clock, asynchronous active-high reset
//   i_req_oct/i_addr_oct    - OCT read request and address
//   i_lock_oct              - OCT keeps the grant while i_req_oct stays high
//   o_gnt_oct               - OCT request accepted this cycle
//   o_rvalid_oct/o_rdata_oct- OCT read return (data is 0 when not valid)
//   *_bfs                   - same set for the BFS core
//   o_enb/o_addrb           - BRAM port-B enable and address
//   i_doutb                 - BRAM port-B read data
//   o_busy                  - at least one read is in flight
// Revision: 1.0 - initial release
// ============================================================================
module branch_rd_arbiter
    import branch_rd_arbiter_pkg::*;
#(
    parameter int DATA_W   = BRANCH_WIDTH,
    parameter int ADDR_W   = BRAM_ADDR_W,
    parameter int BRAM_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_req_oct,
    input  logic [ADDR_W-1:0] i_addr_oct,
    input  logic              i_lock_oct,
    output logic              o_gnt_oct,
    output logic              o_rvalid_oct,
    output logic [DATA_W-1:0] o_rdata_oct,

    input  logic              i_req_bfs,
    input  logic [ADDR_W-1:0] i_addr_bfs,
    input  logic              i_lock_bfs,
    output logic              o_gnt_bfs,
    output logic              o_rvalid_bfs,
    output logic [DATA_W-1:0] o_rdata_bfs,

    output logic              o_enb,
    output logic [ADDR_W-1:0] o_addrb,
    input  logic [DATA_W-1:0] i_doutb,

    output logic              o_busy
);

    // ------------------------------------------------------------------
    // Arbiter state
    // ------------------------------------------------------------------
    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    owner_e            r_last_owner;
    owner_e            w_last_owner_nxt;

    logic              w_gnt_oct;
    logic              w_gnt_bfs;
    logic              w_enb;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [ADDR_W-1:0] r_addr_hold;

    logic              w_ret_valid;
    owner_e            w_ret_owner;
    logic              w_any_valid;
    owner_e            w_issue_owner;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ARB;
            // Starting with OCT as last owner hands the first tie to BFS.
            r_last_owner <= OWN_OCT;
        end else begin
            r_state      <= w_state_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Grant and next-state logic. Grants are combinational so a request
    // can be accepted in the same cycle it is raised.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_oct        = 1'b0;
        w_gnt_bfs        = 1'b0;
        w_state_nxt      = r_state;
        w_last_owner_nxt = r_last_owner;

        case (r_state)
            ARB: begin
                if (i_req_oct && i_req_bfs) begin
                    // Tie: the requester that did not win last time goes.
                    if (r_last_owner == OWN_OCT) begin
                        w_gnt_bfs = 1'b1;
                    end else begin
                        w_gnt_oct = 1'b1;
                    end
                end else begin
                    w_gnt_oct = i_req_oct;
                    w_gnt_bfs = i_req_bfs;
                end

                // A lock only takes effect for the requester that wins.
                if (w_gnt_oct) begin
                    w_last_owner_nxt = OWN_OCT;
                    if (i_lock_oct) begin
                        w_state_nxt = LOCK_OCT;
                    end
                end else if (w_gnt_bfs) begin
                    w_last_owner_nxt = OWN_BFS;
                    if (i_lock_bfs) begin
                        w_state_nxt = LOCK_BFS;
                    end
                end
            end

            LOCK_OCT: begin
                // BFS is blocked. The lock is released at the edge where
                // either req or lock has fallen; no grant is issued to BFS
                // in the cycle OCT drops its request.
                w_gnt_oct = i_req_oct;
                if (w_gnt_oct) begin
                    w_last_owner_nxt = OWN_OCT;
                end
                if (!i_req_oct || !i_lock_oct) begin
                    w_state_nxt = ARB;
                end
            end

            LOCK_BFS: begin
                w_gnt_bfs = i_req_bfs;
                if (w_gnt_bfs) begin
                    w_last_owner_nxt = OWN_BFS;
                end
                if (!i_req_bfs || !i_lock_bfs) begin
                    w_state_nxt = ARB;
                end
            end

            default: begin
                w_state_nxt = ARB;
            end
        endcase

        // Reset is asynchronous, so the combinational grants are forced low
        // for as long as it is asserted to keep every output at zero.
        if (i_rst) begin
            w_gnt_oct = 1'b0;
            w_gnt_bfs = 1'b0;
        end
    end

    assign o_gnt_oct = w_gnt_oct;
    assign o_gnt_bfs = w_gnt_bfs;

    // ------------------------------------------------------------------
    // BRAM port-B drive. The address is muxed from the winner; when no
    // read is issued the last issued address is held on the pins.
    // ------------------------------------------------------------------
    assign w_enb      = w_gnt_oct | w_gnt_bfs;
    assign w_addr_sel = w_gnt_oct ? i_addr_oct : i_addr_bfs;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr_hold <= '0;
        end else if (w_enb) begin
            r_addr_hold <= w_addr_sel;
        end
    end

    assign o_enb   = w_enb;
    assign o_addrb = w_enb ? w_addr_sel : r_addr_hold;

    // ------------------------------------------------------------------
    // Return path: the owner tag travels alongside the BRAM latency so the
    // data arriving in cycle N+BRAM_LAT is steered to the right requester.
    // ------------------------------------------------------------------
    assign w_issue_owner = w_gnt_bfs ? OWN_BFS : OWN_OCT;

    rd_lat_pipe #(
        .LAT (BRAM_LAT)
    ) u_rd_lat_pipe (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (w_enb),
        .i_owner     (w_issue_owner),
        .o_valid     (w_ret_valid),
        .o_owner     (w_ret_owner),
        .o_any_valid (w_any_valid)
    );

    assign o_rvalid_oct = w_ret_valid && (w_ret_owner == OWN_OCT);
    assign o_rvalid_bfs = w_ret_valid && (w_ret_owner == OWN_BFS);

    // Data is zeroed outside the valid cycle so neither core ever sees the
    // other's branch word on its bus.
    assign o_rdata_oct = o_rvalid_oct ? i_doutb : '0;
    assign o_rdata_bfs = o_rvalid_bfs ? i_doutb : '0;

    assign o_busy = w_any_valid;

endmodule : branch_rd_arbiter
`default_nettype wire

// File: tb/tb_branch_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_rd_arbiter
// Purpose : Directed self-checking bench. Two arbiters (BRAM_LAT = 1 and 2)
//           share the same request stimulus, each with its own BRAM model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_branch_rd_arbiter;

    localparam int DW = 152;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_oct, lock_oct, req_bfs, lock_bfs;
    logic [AW-1:0] addr_oct, addr_bfs;

    logic          gnt_oct1, gnt_bfs1, rv_oct1, rv_bfs1, enb1, busy1;
    logic [DW-1:0] rd_oct1, rd_bfs1, doutb1, dq1;
    logic [AW-1:0] addrb1;
    logic          gnt_oct2, gnt_bfs2, rv_oct2, rv_bfs2, enb2, busy2;
    logic [DW-1:0] rd_oct2, rd_bfs2, doutb2, dq2a, dq2b;
    logic [AW-1:0] addrb2;

    int n_vec = 0;
    int n_err = 0;

    // Status bundles: {gnt_oct, gnt_bfs, enb, rvalid_oct, rvalid_bfs, busy}
    logic [5:0] st1, st2;
    assign st1 = {gnt_oct1, gnt_bfs1, enb1, rv_oct1, rv_bfs1, busy1};
    assign st2 = {gnt_oct2, gnt_bfs2, enb2, rv_oct2, rv_bfs2, busy2};

    always #5 clk = ~clk;

    // Branch word stored at each address: payload tag plus 8 distinct children.
    function automatic logic [DW-1:0] bw(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w[151:128] = {8'hB5, a};
        for (int k = 0; k < 8; k++) w[k*16 +: 16] = a + 16'(k * 16'h0111);
        return w;
    endfunction

    // BRAM models
    always @(posedge clk) if (enb1) dq1 <= bw(addrb1);
    assign doutb1 = dq1;
    always @(posedge clk) begin
        if (enb2) dq2a <= bw(addrb2);
        dq2b <= dq2a;
    end
    assign doutb2 = dq2b;

    branch_rd_arbiter #(.DATA_W(DW), .ADDR_W(AW), .BRAM_LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_req_oct(req_oct), .i_addr_oct(addr_oct), .i_lock_oct(lock_oct),
        .o_gnt_oct(gnt_oct1), .o_rvalid_oct(rv_oct1), .o_rdata_oct(rd_oct1),
        .i_req_bfs(req_bfs), .i_addr_bfs(addr_bfs), .i_lock_bfs(lock_bfs),
        .o_gnt_bfs(gnt_bfs1), .o_rvalid_bfs(rv_bfs1), .o_rdata_bfs(rd_bfs1),
        .o_enb(enb1), .o_addrb(addrb1), .i_doutb(doutb1), .o_busy(busy1)
    );

    branch_rd_arbiter #(.DATA_W(DW), .ADDR_W(AW), .BRAM_LAT(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst),
        .i_req_oct(req_oct), .i_addr_oct(addr_oct), .i_lock_oct(lock_oct),
        .o_gnt_oct(gnt_oct2), .o_rvalid_oct(rv_oct2), .o_rdata_oct(rd_oct2),
        .i_req_bfs(req_bfs), .i_addr_bfs(addr_bfs), .i_lock_bfs(lock_bfs),
        .o_gnt_bfs(gnt_bfs2), .o_rvalid_bfs(rv_bfs2), .o_rdata_bfs(rd_bfs2),
        .o_enb(enb2), .o_addrb(addrb2), .i_doutb(doutb2), .o_busy(busy2)
    );

    // Advance to just after the next rising edge; inputs are driven here and
    // outputs are checked #2 later, well before the following edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_oct = 1'b0; lock_oct = 1'b0; addr_oct = '0;
        req_bfs = 1'b0; lock_bfs = 1'b0; addr_bfs = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_oct = 1'b1; addr_oct = 16'h00A5;
        req_bfs = 1'b1; addr_bfs = 16'h1234;
        cyc();
        #2;
        if (st1 !== 6'b000000) begin n_err++; $display("FAIL rst_status1: got %b want %b", st1, 6'b000000); end
        n_vec++;
        if (st2 !== 6'b000000) begin n_err++; $display("FAIL rst_status2: got %b want %b", st2, 6'b000000); end
        n_vec++;
        if (addrb1 !== 16'h0000) begin n_err++; $display("FAIL rst_addrb1: got %h want %h", addrb1, 16'h0000); end
        n_vec++;
        if (rd_bfs1 !== '0 || rd_oct1 !== '0) begin n_err++; $display("FAIL rst_rdata1: got %h/%h want 0", rd_oct1, rd_bfs1); end
        n_vec++;
    endtask

    task automatic test_bfs_single();
        do_reset();
        req_bfs = 1'b1; addr_bfs = 16'd2;
        #2;
        if (st1 !== 6'b011000) begin n_err++; $display("FAIL single_c0_status1: got %b want %b", st1, 6'b011000); end
        n_vec++;
        if (st2 !== 6'b011000) begin n_err++; $display("FAIL single_c0_status2: got %b want %b", st2, 6'b011000); end
        n_vec++;
        if (addrb1 !== 16'd2) begin n_err++; $display("FAIL single_c0_addrb: got %0d want %0d", addrb1, 2); end
        n_vec++;
        cyc();
        req_bfs = 1'b0; addr_bfs = 16'd77;
        #2;
        if (st1 !== 6'b000011) begin n_err++; $display("FAIL single_c1_status1: got %b want %b", st1, 6'b000011); end
        n_vec++;
        if (rd_bfs1 !== bw(16'd2)) begin n_err++; $display("FAIL single_c1_rdata_bfs1: got %h want %h", rd_bfs1, bw(16'd2)); end
        n_vec++;
        if (rd_oct1 !== '0) begin n_err++; $display("FAIL single_c1_rdata_oct1: got %h want 0", rd_oct1); end
        n_vec++;
        if (addrb1 !== 16'd2) begin n_err++; $display("FAIL single_idle_addr_hold: got %0d want %0d", addrb1, 2); end
        n_vec++;
        if (st2 !== 6'b000001) begin n_err++; $display("FAIL single_c1_status2: got %b want %b", st2, 6'b000001); end
        n_vec++;
        cyc();
        #2;
        if (st1 !== 6'b000000 || rd_bfs1 !== '0) begin n_err++; $display("FAIL single_c2_status1: got %b want %b", st1, 6'b000000); end
        n_vec++;
        if (st2 !== 6'b000011) begin n_err++; $display("FAIL single_c2_status2: got %b want %b", st2, 6'b000011); end
        n_vec++;
        if (rd_bfs2 !== bw(16'd2)) begin n_err++; $display("FAIL single_c2_rdata_bfs2: got %h want %h", rd_bfs2, bw(16'd2)); end
        n_vec++;
        cyc();
        #2;
        if (st2 !== 6'b000000) begin n_err++; $display("FAIL single_c3_status2: got %b want %b", st2, 6'b000000); end
        n_vec++;
    endtask

    task automatic test_alternate();
        logic [5:0] exp_b;
        logic e, ep;
        exp_b = 6'b010101;   // bit k: BFS wins cycle k (BFS first after reset)
        do_reset();
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) cyc();
            req_oct = (k < 6); addr_oct = 16'd5;
            req_bfs = (k < 6); addr_bfs = 16'd9;
            #2;
            if (k < 6) begin
                e = exp_b[k];
                if ({gnt_oct1, gnt_bfs1, enb1} !== {~e, e, 1'b1}) begin
                    n_err++; $display("FAIL alt_gnt c%0d: got %b want %b", k, {gnt_oct1, gnt_bfs1, enb1}, {~e, e, 1'b1});
                end
                n_vec++;
                if (addrb1 !== (e ? 16'd9 : 16'd5)) begin
                    n_err++; $display("FAIL alt_addrb c%0d: got %0d want %0d", k, addrb1, e ? 9 : 5);
                end
                n_vec++;
            end
            if (k >= 1) begin
                ep = exp_b[k-1];
                if ({rv_oct1, rv_bfs1} !== {~ep, ep}) begin
                    n_err++; $display("FAIL alt_rvalid1 c%0d: got %b want %b", k, {rv_oct1, rv_bfs1}, {~ep, ep});
                end
                n_vec++;
                if ((ep ? rd_bfs1 : rd_oct1) !== bw(ep ? 16'd9 : 16'd5)) begin
                    n_err++; $display("FAIL alt_rdata1 c%0d: got %h want %h", k, ep ? rd_bfs1 : rd_oct1, bw(ep ? 16'd9 : 16'd5));
                end
                n_vec++;
            end
            if (k >= 2) begin
                ep = exp_b[k-2];
                if ({rv_oct2, rv_bfs2} !== {~ep, ep}) begin
                    n_err++; $display("FAIL alt_rvalid2 c%0d: got %b want %b", k, {rv_oct2, rv_bfs2}, {~ep, ep});
                end
                n_vec++;
            end
        end
    endtask

    task automatic test_lock();
        logic [4:0] exp_b;
        do_reset();
        // BFS wins the tie with its lock up and keeps the port for 4 reads.
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) cyc();
            req_oct = 1'b1; addr_oct = 16'd5;
            req_bfs = (k < 4); lock_bfs = (k < 4); addr_bfs = (k < 4) ? 16'(2 + k) : 16'd0;
            #2;
            if (k < 4) begin
                if ({gnt_oct1, gnt_bfs1} !== 2'b01 || addrb1 !== 16'(2 + k)) begin
                    n_err++; $display("FAIL lock_bfs_burst c%0d: got gnt %b addr %0d want gnt 01 addr %0d", k, {gnt_oct1, gnt_bfs1}, addrb1, 2 + k);
                end
                n_vec++;
            end else if (k == 4) begin
                if ({gnt_oct1, gnt_bfs1, enb1} !== 3'b000) begin
                    n_err++; $display("FAIL lock_release_gap: got %b want %b", {gnt_oct1, gnt_bfs1, enb1}, 3'b000);
                end
                n_vec++;
            end else begin
                if ({gnt_oct1, gnt_bfs1} !== 2'b10 || addrb1 !== 16'd5) begin
                    n_err++; $display("FAIL lock_oct_after: got gnt %b addr %0d want gnt 10 addr 5", {gnt_oct1, gnt_bfs1}, addrb1);
                end
                n_vec++;
            end
            if (k >= 1 && k <= 4) begin
                if (rv_bfs1 !== 1'b1 || rd_bfs1 !== bw(16'(1 + k))) begin
                    n_err++; $display("FAIL lock_return c%0d: got v=%b %h want v=1 %h", k, rv_bfs1, rd_bfs1, bw(16'(1 + k)));
                end
                n_vec++;
            end
        end
        // A lock raised by the tie loser does nothing until it wins.
        do_reset();
        exp_b = 5'b10001;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) cyc();
            req_oct = 1'b1; addr_oct = 16'd7; lock_oct = (k < 3);
            req_bfs = 1'b1; addr_bfs = 16'd8; lock_bfs = 1'b0;
            #2;
            if ({gnt_oct1, gnt_bfs1} !== {~exp_b[k], exp_b[k]}) begin
                n_err++; $display("FAIL loser_lock c%0d: got %b want %b", k, {gnt_oct1, gnt_bfs1}, {~exp_b[k], exp_b[k]});
            end
            n_vec++;
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  exp_b;
        logic [15:0] exp_a [6];
        logic        ep;
        exp_b = 6'b010101;
        exp_a = '{16'd20, 16'd10, 16'd21, 16'd11, 16'd22, 16'd12};
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) cyc();
            req_oct = (k < 6); addr_oct = 16'(10 + k / 2);
            req_bfs = (k < 6); addr_bfs = 16'(20 + (k + 1) / 2);
            #2;
            if (k < 6) begin
                if ({gnt_oct2, gnt_bfs2} !== {~exp_b[k], exp_b[k]} || addrb2 !== exp_a[k]) begin
                    n_err++; $display("FAIL b2b_issue c%0d: got gnt %b addr %0d want gnt %b addr %0d", k, {gnt_oct2, gnt_bfs2}, addrb2, {~exp_b[k], exp_b[k]}, exp_a[k]);
                end
                n_vec++;
            end
            if (k >= 2 && k <= 7) begin
                ep = exp_b[k-2];
                if ({rv_oct2, rv_bfs2} !== {~ep, ep} || (ep ? rd_bfs2 : rd_oct2) !== bw(exp_a[k-2])) begin
                    n_err++; $display("FAIL b2b_return c%0d: got v %b data %h want v %b data %h", k, {rv_oct2, rv_bfs2}, ep ? rd_bfs2 : rd_oct2, {~ep, ep}, bw(exp_a[k-2]));
                end
                n_vec++;
            end else begin
                if ({rv_oct2, rv_bfs2} !== 2'b00) begin
                    n_err++; $display("FAIL b2b_no_return c%0d: got %b want 00", k, {rv_oct2, rv_bfs2});
                end
                n_vec++;
            end
            if (busy2 !== (k >= 1 && k <= 7)) begin
                n_err++; $display("FAIL b2b_busy c%0d: got %b want %b", k, busy2, (k >= 1 && k <= 7));
            end
            n_vec++;
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_oct = 1'b1; addr_oct = 16'd3;
        req_bfs = 1'b1; addr_bfs = 16'd4;
        #2;                 // cycle 0: BFS
        cyc();
        #2;                 // cycle 1: OCT
        cyc();
        rst = 1'b1;         // two reads in flight in the LAT=2 arbiter
        #2;
        if (st1 !== 6'b000000 || st2 !== 6'b000000) begin
            n_err++; $display("FAIL midrst_status: got %b/%b want 000000/000000", st1, st2);
        end
        n_vec++;
        if (addrb1 !== 16'd0 || addrb2 !== 16'd0 || rd_oct1 !== '0 || rd_bfs2 !== '0) begin
            n_err++; $display("FAIL midrst_bus: got addr %0d/%0d want 0/0 with zero data", addrb1, addrb2);
        end
        n_vec++;
        cyc();
        cyc();
        rst = 1'b0;
        #2;
        if ({gnt_oct1, gnt_bfs1} !== 2'b01 || {gnt_oct2, gnt_bfs2, rv_oct2, rv_bfs2} !== 4'b0100) begin
            n_err++; $display("FAIL midrst_first_tie: got %b/%b want 01/0100", {gnt_oct1, gnt_bfs1}, {gnt_oct2, gnt_bfs2, rv_oct2, rv_bfs2});
        end
        n_vec++;
        cyc();
        clear_inputs();
        #2;
        if ({rv_oct1, rv_bfs1, rv_oct2, rv_bfs2} !== 4'b0100) begin
            n_err++; $display("FAIL midrst_no_stale: got %b want %b", {rv_oct1, rv_bfs1, rv_oct2, rv_bfs2}, 4'b0100);
        end
        n_vec++;
        cyc();
        #2;
        if ({rv_oct2, rv_bfs2} !== 2'b01 || rd_bfs2 !== bw(16'd4)) begin
            n_err++; $display("FAIL midrst_new_read2: got %b %h want 01 %h", {rv_oct2, rv_bfs2}, rd_bfs2, bw(16'd4));
        end
        n_vec++;
    endtask

    task automatic test_oct_then_tie();
        do_reset();
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) cyc();
            req_oct = 1'b1; addr_oct = 16'd1;   // leaf marker address passes through
            req_bfs = (k == 3); addr_bfs = 16'd0;
            #2;
            if (k < 3) begin
                if ({gnt_oct1, gnt_bfs1} !== 2'b10 || addrb1 !== 16'd1) begin
                    n_err++; $display("FAIL oct_alone c%0d: got gnt %b addr %0d want 10 addr 1", k, {gnt_oct1, gnt_bfs1}, addrb1);
                end
                n_vec++;
            end else begin
                if ({gnt_oct1, gnt_bfs1} !== 2'b01 || addrb1 !== 16'd0) begin
                    n_err++; $display("FAIL tie_after_oct: got gnt %b addr %0d want 01 addr 0", {gnt_oct1, gnt_bfs1}, addrb1);
                end
                n_vec++;
            end
        end
        cyc();
        clear_inputs();
        #2;
        if (rv_bfs1 !== 1'b1 || rd_bfs1 !== bw(16'd0)) begin
            n_err++; $display("FAIL addr0_return: got %b %h want 1 %h", rv_bfs1, rd_bfs1, bw(16'd0));
        end
        n_vec++;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_bfs_single();
        test_alternate();
        test_lock();
        test_back_to_back();
        test_reset_midflight();
        test_oct_then_tie();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d checks want completion", n_vec);
        $fatal(1, "timeout");
    end

endmodule : tb_branch_rd_arbiter
`default_nettype wire
